// File: rtl/int_cmd_in_writer.sv
// Write-side controller for the internal command-in queue.
// Checks free slots, streams payload, then commits the header and notifies.
module int_cmd_in_writer #(
   parameter int         MAX_ACCS           = 16,
   parameter int         ACC_BITS           = $clog2(MAX_ACCS),
   parameter int         SUBQUEUE_BITS      = 6,
   parameter int         RETRY_CYCLES       = 16,
   parameter int         ENTRY_VALID_OFFSET = 63,
   parameter int         CMD_TYPE_L         = 0,
   parameter int         NUM_ARGS_OFFSET    = 8,
   parameter logic [3:0] EXEC_TASK_CODE     = 4'h1
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [63:0]                       inStream_TDATA,
   input  logic                              inStream_TVALID,
   output logic                              inStream_TREADY,
   input  logic [ACC_BITS-1:0]               inStream_TDEST,
   input  logic                              inStream_TLAST,
   output logic [SUBQUEUE_BITS+ACC_BITS-1:0] intCmdInQueue_addr,
   output logic                              intCmdInQueue_en,
   output logic                              intCmdInQueue_we,
   output logic [63:0]                       intCmdInQueue_din,
   input  logic [63:0]                       intCmdInQueue_dout,
   output logic [ACC_BITS-1:0]               sched_queue_nempty_address,
   output logic                              sched_queue_nempty_write,
   output logic                              len_err
);

   localparam int BO_W = $clog2(RETRY_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_BACKOFF,
      S_WRITE,
      S_DRAIN,
      S_COMMIT,
      S_NOTIFY
   } state_t;

   state_t state, state_nxt;

   logic [63:0]              hdr;
   logic [ACC_BITS-1:0]      tgt;
   logic [5:0]               len;
   logic [5:0]               rd_k;
   logic                     chk_vld;
   logic [BO_W-1:0]          bo_cnt;
   logic [5:0]               wk;
   logic [SUBQUEUE_BITS-1:0] wr_ptr [MAX_ACCS];

   logic [SUBQUEUE_BITS-1:0] base;
   logic                     hs;
   logic                     rd_issue;
   logic                     slot_busy;
   logic                     chk_fail;
   logic                     chk_done;
   logic                     bo_done;
   logic                     wk_last;
   logic                     unused_dout;

   // Command length in slots: header plus argument pairs and fixed words.
   function automatic logic [5:0] cmd_len(
      input logic [3:0] ctype,
      input logic [3:0] nargs
   );
      logic [5:0] fixed;
      fixed   = (ctype == EXEC_TASK_CODE) ? 6'd3 : 6'd4;
      cmd_len = fixed + {1'b0, nargs, 1'b0};
   endfunction

   assign base        = wr_ptr[tgt];
   assign hs          = inStream_TVALID && inStream_TREADY;
   assign rd_issue    = (state == S_CHECK) && (rd_k < len);
   assign slot_busy   = intCmdInQueue_dout[ENTRY_VALID_OFFSET];
   assign chk_fail    = (state == S_CHECK) && chk_vld && slot_busy;
   assign chk_done    = (state == S_CHECK) && chk_vld && !slot_busy
                        && (rd_k == len);
   assign bo_done     = (bo_cnt == BO_W'(RETRY_CYCLES - 1));
   assign wk_last     = (wk == len - 6'd1);
   assign unused_dout = ^intCmdInQueue_dout;

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (inStream_TVALID) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (chk_fail) begin
               state_nxt = S_BACKOFF;
            end else if (chk_done) begin
               state_nxt = S_WRITE;
            end
         end
         S_BACKOFF: begin
            if (bo_done) state_nxt = S_CHECK;
         end
         S_WRITE: begin
            if (hs) begin
               if (inStream_TLAST && wk_last) begin
                  state_nxt = S_COMMIT;
               end else if (inStream_TLAST) begin
                  state_nxt = S_IDLE;
               end else if (wk_last) begin
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (hs && inStream_TLAST) state_nxt = S_IDLE;
         end
         S_COMMIT: state_nxt = S_NOTIFY;
         S_NOTIFY: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs; everything is held low while reset is asserted.
   always_comb begin
      inStream_TREADY            = 1'b0;
      intCmdInQueue_addr         = '0;
      intCmdInQueue_en           = 1'b0;
      intCmdInQueue_we           = 1'b0;
      intCmdInQueue_din          = '0;
      sched_queue_nempty_address = '0;
      sched_queue_nempty_write   = 1'b0;
      len_err                    = 1'b0;
      if (rstn) begin
         unique case (state)
            S_CHECK: begin
               intCmdInQueue_en   = rd_issue;
               intCmdInQueue_addr = {tgt, base + SUBQUEUE_BITS'(rd_k)};
            end
            S_WRITE: begin
               inStream_TREADY = 1'b1;
               if (hs && (wk != 6'd0)) begin
                  intCmdInQueue_en   = 1'b1;
                  intCmdInQueue_we   = 1'b1;
                  intCmdInQueue_addr = {tgt, base + SUBQUEUE_BITS'(wk)};
                  intCmdInQueue_din  = inStream_TDATA;
               end
               len_err = hs && (inStream_TLAST != wk_last);
            end
            S_DRAIN: begin
               inStream_TREADY = 1'b1;
            end
            S_COMMIT: begin
               intCmdInQueue_en   = 1'b1;
               intCmdInQueue_we   = 1'b1;
               intCmdInQueue_addr = {tgt, base};
               intCmdInQueue_din  = hdr;
               intCmdInQueue_din[ENTRY_VALID_OFFSET] = 1'b1;
            end
            S_NOTIFY: begin
               sched_queue_nempty_write   = 1'b1;
               sched_queue_nempty_address = tgt;
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath: header latch, check/backoff/beat counters, write pointers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hdr     <= '0;
         tgt     <= '0;
         len     <= '0;
         rd_k    <= '0;
         chk_vld <= 1'b0;
         bo_cnt  <= '0;
         wk      <= '0;
         for (int i = 0; i < MAX_ACCS; i++) begin
            wr_ptr[i] <= '0;
         end
      end else begin
         if (state == S_IDLE && inStream_TVALID) begin
            hdr <= inStream_TDATA;
            tgt <= inStream_TDEST;
            len <= cmd_len(inStream_TDATA[CMD_TYPE_L+:4],
                           inStream_TDATA[NUM_ARGS_OFFSET+:4]);
         end

         if (state != S_CHECK) begin
            rd_k    <= '0;
            chk_vld <= 1'b0;
         end else begin
            chk_vld <= rd_issue;
            if (rd_issue) rd_k <= rd_k + 6'd1;
         end

         if (state != S_BACKOFF) begin
            bo_cnt <= '0;
         end else begin
            bo_cnt <= bo_cnt + BO_W'(1);
         end

         if (state != S_WRITE) begin
            wk <= '0;
         end else if (hs) begin
            wk <= wk + 6'd1;
         end

         if (state == S_COMMIT) begin
            wr_ptr[tgt] <= base + SUBQUEUE_BITS'(len);
         end
      end
   end

endmodule
